mmio_uart_tx: RTL and testbench
===============================

# mmio_uart_tx

Memory-mapped UART transmitter that sits directly downstream of the single-cycle core's data-memory port. It snoops the `MemWrite`, `DataAdr` and `WriteData` outputs of `top` in parallel with `dmem`. Each store to the TX address pushes the low byte into a FIFO. A serializer drains the FIFO onto a standard 8N1 serial line. The block never drives `ReadData` and never stalls the core, so dropped bytes are flagged rather than back-pressured.

## Interface
- `TX_ADDR`, default 32'h0000_0100: byte address that triggers a push. Full 32-bit compare.
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Must be ≥2.
- `FIFO_DEPTH`, default 8: FIFO entries. Must be a power of 2 and ≥2.
- `clk`  in  1: core clock. All state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset. State clears immediately while `reset`=0.
- `MemWrite`  in  1: store strobe from `top`.
- `DataAdr`  in  32: store address from `top`.
- `WriteData`  in  32: store data from `top`. Only bits [7:0] are used.
- `tx`  out  1: serial line. Idle high. Registered.
- `tx_busy`  out  1: high whenever the FSM is not IDLE. Registered.
- `fifo_full`  out  1: FIFO count equals `FIFO_DEPTH`.
- `overflow`  out  1: sticky flag; set when a push is dropped; cleared only by reset.

## Operation
- Push condition: `MemWrite`=1 and `DataAdr`=`TX_ADDR` at a rising edge. Stores to any other address are ignored.
- Push writes `WriteData[7:0]` at the write pointer.
- Pointers are log2(`FIFO_DEPTH`) bits wide and wrap naturally.
- Count is log2(`FIFO_DEPTH`)+1 bits wide.
- Push when full with no pop in the same cycle: the byte is discarded, `overflow` is set, and pointers and count are unchanged.
- Push and pop in the same cycle: both take effect and the count is unchanged. This includes the full case, where the push is accepted.
- Push and pop never occur in the same cycle while the FIFO is empty, because a pop requires count≠0 at the edge.
- FSM states:
  - IDLE: `tx`=1. If count≠0, pop the head into the shift register, clear the baud counter and bit index, and go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `tx`=shift[0], LSB first. After each `CLKS_PER_BIT` cycles, shift right and increment the bit index. After bit 7, go to PARITY if enabled, otherwise STOP.
  - PARITY: present only with the config macro. `tx`=XOR of the 8 data bits (even parity) for `CLKS_PER_BIT` cycles, then go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- Baud counter counts 0..`CLKS_PER_BIT`-1. A bit period ends when the counter equals `CLKS_PER_BIT`-1.
- Reset values: `tx`=1, `tx_busy`=0, `fifo_full`=0, `overflow`=0, FSM=IDLE, pointers=0, count=0, baud counter=0.

## Timing
- A store sampled at edge k is visible in count after edge k. `fifo_full` is combinational from count.
- If the FSM is IDLE with an empty FIFO, the pop occurs at edge k+1. `tx` falls and `tx_busy` rises after edge k+1.
- Frame length is 10×`CLKS_PER_BIT` cycles, or 11× with parity. With the default parameter, 160 cycles (176 with parity).
- Back-to-back frames: the STOP last cycle is followed by exactly one IDLE cycle, then the next START. Inter-frame gap is 1 cycle.
- The core may issue a store every cycle. Sustained rate beyond the FIFO depth is lost and flagged.
- Reset asserted mid-frame: `tx` returns to 1 asynchronously, with no partial stop bit. FIFO contents are discarded.
- After reset deasserts, the first edge sees an empty FIFO.

## Configuration
- `MMIO_UART_PARITY_EN` defined: the PARITY state is compiled in. Frames are 8E1, 11 bit periods.
- Not defined: the PARITY state and its XOR logic are absent. Frames are 8N1, 10 bit periods.
- Port list is identical in both builds.

## Test plan
- Reset mid-frame: store 8'hFF, then drop `reset` low at cycle 50 of the frame → `tx`=1 immediately. After release, `tx_busy`=0, `fifo_full`=0, and no further frame is sent.
- Single byte: store 32'h0000_0041 to 32'h100 at edge 0 → `tx` falls after edge 1. Line shows 0,1,0,0,0,0,0,1,0,1, each bit 16 cycles. `tx_busy` drops after edge 161.
- Address filter: stores to 32'h104 and 32'h0FF, and a load to 32'h100 (`MemWrite`=0) → `tx` stays 1 and `tx_busy` stays 0.
- Burst overflow: 10 consecutive stores, bytes 1..10, one per cycle, from edge 0 → byte 1 popped at edge 1. Bytes 2..9 fill the FIFO, byte 10 is dropped, and `overflow`=1. Line carries 1..9 with 1-cycle gaps.
- Full plus simultaneous pop: fill 8 while a frame is in STOP, then store at the IDLE-pop cycle → push accepted, count stays 8, `overflow` stays 0.
- Parity build: store 8'h07 → 11 bit periods, parity bit 1. Store 8'h03 → parity bit 0.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped UART transmitter snooping the core's store port
//
// Stores with MemWrite=1 and DataAdr=TX_ADDR push WriteData[7:0] into a FIFO.
// A serializer drains the FIFO as 8N1 frames, or 8E1 when the optional macro
// MMIO_UART_PARITY_EN is defined. The core is never stalled: a push into a
// full FIFO (with no pop in the same cycle) is dropped and flagged.
//
// Ports:
//   clk        in   core clock, rising edge
//   reset      in   asynchronous active-low reset
//   MemWrite   in   store strobe
//   DataAdr    in   [31:0] store address, full compare against TX_ADDR
//   WriteData  in   [31:0] store data, only [7:0] used
//   tx         out  serial line, idle high, registered
//   tx_busy    out  high while the serializer is not idle, registered
//   fifo_full  out  FIFO holds FIFO_DEPTH bytes
//   overflow   out  sticky, set when a push is dropped; cleared by reset only
module mmio_uart_tx #(
    parameter logic [31:0] TX_ADDR      = 32'h0000_0100,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic        tx,
    output logic        tx_busy,
    output logic        fifo_full,
    output logic        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [BW-1:0] BAUD_ONE = BW'(1);
    localparam logic [BW-1:0] BAUD_END = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef MMIO_UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t          r_state;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic [BW-1:0]   r_baud;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_tx;
    logic            r_busy;
    logic            r_overflow;
`ifdef MMIO_UART_PARITY_EN
    logic            r_parity;
`endif

    logic            w_push;
    logic            w_pop;
    logic            w_push_ok;
    logic            w_baud_end;
    logic            w_unused_data;

    assign w_push     = MemWrite && (DataAdr == TX_ADDR);
    // A pop only happens from IDLE with data present, so an empty FIFO never
    // sees a simultaneous push and pop.
    assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
    // When full, a push is still accepted if the head leaves on the same edge.
    assign w_push_ok  = w_push && ((r_count != CNT_FULL) || w_pop);
    assign w_baud_end = (r_baud == BAUD_END);
    assign w_unused_data = ^WriteData[31:8];

    assign tx        = r_tx;
    assign tx_busy   = r_busy;
    assign fifo_full = (r_count == CNT_FULL);
    assign overflow  = r_overflow;

    // Storage needs no reset: reset clears the pointers and count instead.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= WriteData[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (w_pop && !w_push_ok) begin
                r_count <= r_count - CNT_ONE;
            end
            if (w_push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
`ifdef MMIO_UART_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift  <= r_mem[r_rd_ptr];
`ifdef MMIO_UART_PARITY_EN
                        r_parity <= ^r_mem[r_rd_ptr];
`endif
                        r_baud   <= '0;
                        r_bit    <= '0;
                        r_tx     <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= S_START;
                    end
                end
                S_START: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + BAUD_ONE;
                    end
                end
                S_DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= S_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
`endif
                        end else begin
                            // Present the next bit directly from shift[1] so tx
                            // stays registered without a one-cycle lag.
                            r_shift <= r_shift >> 1;
                            r_bit   <= r_bit + 3'd1;
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_ONE;
                    end
                end
`ifdef MMIO_UART_PARITY_EN
                S_PARITY: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end else begin
                        r_baud <= r_baud + BAUD_ONE;
                    end
                end
`endif
                S_STOP: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_baud <= r_baud + BAUD_ONE;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - self-checking bench for mmio_uart_tx
module tb_mmio_uart_tx;

`ifdef MMIO_UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;
    logic        tx;
    logic        tx_busy;
    logic        fifo_full;
    logic        overflow;

    mmio_uart_tx dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .tx        (tx),
        .tx_busy   (tx_busy),
        .fifo_full (fifo_full),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        frame;
        logic [9:0]  bits;
        logic        par;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [10:0] exp_frame(input logic [7:0] b);
`ifdef MMIO_UART_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {2'b01, b, 1'b0};
`endif
    endfunction

    task automatic store(input logic we, input logic [31:0] a, input logic [31:0] d, output int e);
        MemWrite  = we;
        DataAdr   = a;
        WriteData = d;
        @(negedge clk);
        e = cyc;
        MemWrite  = 1'b0;
        DataAdr   = '0;
        WriteData = '0;
    endtask

    task automatic recv_frame(output logic [10:0] bits, output int s, output int e, output bit ok);
        bits = '0;
        s = -1;
        e = -1;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) return;
        s = cyc;
        for (int i = 0; i < NB; i++) begin
            repeat ((i == 0) ? CPB/2 : CPB) @(negedge clk);
            bits[i] = tx;
        end
        ok = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (tx_busy === 1'b0) begin
                ok = 1'b1;
                e = cyc;
                break;
            end
        end
    endtask

    task automatic idle_window(input string name, input int n);
        bit bad;
        bad = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1;
        end
        check(name, {31'd0, bad}, 32'd0);
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic reset_mid(input int offset, input logic exp_tx_before);
        int e;
        store(1'b1, 32'h100, 32'hFF, e);
        store(1'b1, 32'h100, 32'h12, e);
        repeat (offset - 1) @(negedge clk);
        check("rst_pre_tx", {31'd0, tx}, {31'd0, exp_tx_before});
        #2 reset = 1'b0;
        #1;
        check("rst_async_tx", {31'd0, tx}, 32'd1);
        check("rst_async_busy", {31'd0, tx_busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        check("rst_full", {31'd0, fifo_full}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        idle_window("rst_no_frame", 250);
    endtask

    logic [10:0] r_bits;
    logic [10:0] r_exp;
    int          r_s, r_e, r_e0, r_prev_s, t_e;
    bit          r_ok;
    logic [7:0]  full_bytes[10];

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0100, 32'h0000_0041, 1'b1, 10'h282, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_0100, 32'hFFFF_FF00, 1'b1, 10'h200, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_0100, 32'h0000_00A5, 1'b1, 10'h34A, 1'b0};
        vecs[3] = '{1'b1, 32'h0000_0104, 32'h0000_0055, 1'b0, 10'h3FF, 1'b0};
        vecs[4] = '{1'b1, 32'h0000_00FF, 32'h0000_0055, 1'b0, 10'h3FF, 1'b0};
        vecs[5] = '{1'b0, 32'h0000_0100, 32'h0000_0055, 1'b0, 10'h3FF, 1'b0};
        vecs[6] = '{1'b1, 32'h0000_0100, 32'h0000_0007, 1'b1, 10'h20E, 1'b1};
        vecs[7] = '{1'b1, 32'h0000_0100, 32'h0000_0003, 1'b1, 10'h206, 1'b0};
        vecs[8] = '{1'b1, 32'h8000_0100, 32'h0000_0055, 1'b0, 10'h3FF, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_busy", {31'd0, tx_busy}, 32'd0);
        check("reset_full", {31'd0, fifo_full}, 32'd0);
        check("reset_ovf", {31'd0, overflow}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Table-driven single stores
        for (int v = 0; v < 9; v++) begin
            store(vecs[v].we, vecs[v].addr, vecs[v].data, r_e0);
            if (vecs[v].frame) begin
                check("pre_pop_tx", {31'd0, tx}, 32'd1);
                check("pre_pop_busy", {31'd0, tx_busy}, 32'd0);
`ifdef MMIO_UART_PARITY_EN
                r_exp = {1'b1, vecs[v].par, vecs[v].bits[8:0]};
`else
                r_exp = {1'b0, vecs[v].bits};
`endif
                recv_frame(r_bits, r_s, r_e, r_ok);
                check("vec_frame_ok", {31'd0, r_ok}, 32'd1);
                check("vec_frame_bits", {21'd0, r_bits}, {21'd0, r_exp});
                check("vec_start_edge", r_s, r_e0 + 1);
                check("vec_busy_end", r_e, r_s + NB*CPB);
            end else begin
                idle_window("addr_filter_idle", 60);
            end
        end

        // Burst overflow: ten back-to-back stores
        fork
            begin
                for (int b = 1; b <= 10; b++) begin
                    store(1'b1, 32'h100, b, t_e);
                    if (b == 1) r_e0 = t_e;
                    if (b == 9) begin
                        check("burst_full", {31'd0, fifo_full}, 32'd1);
                        check("burst_ovf_before", {31'd0, overflow}, 32'd0);
                    end
                    if (b == 10) check("burst_ovf_set", {31'd0, overflow}, 32'd1);
                end
            end
            begin
                for (int n = 0; n < 9; n++) begin
                    recv_frame(r_bits, r_s, r_e, r_ok);
                    check("burst_frame_ok", {31'd0, r_ok}, 32'd1);
                    check("burst_frame_bits", {21'd0, r_bits}, {21'd0, exp_frame(8'(n + 1))});
                    if (n == 0) check("burst_first_start", r_s, r_e0 + 1);
                    else check("burst_gap", r_s, r_prev_s + NB*CPB + 1);
                    r_prev_s = r_s;
                end
            end
        join
        idle_window("burst_no_tenth", 200);
        check("burst_ovf_sticky", {31'd0, overflow}, 32'd1);
        pulse_reset();
        check("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Full FIFO with simultaneous push at the IDLE pop cycle
        full_bytes[0] = 8'h5A;
        for (int i = 1; i <= 8; i++) full_bytes[i] = 8'h80 + 8'(i - 1);
        full_bytes[9] = 8'hC3;
        fork
            begin
                store(1'b1, 32'h100, {24'd0, full_bytes[0]}, r_e0);
                for (int i = 1; i <= 8; i++) store(1'b1, 32'h100, {24'd0, full_bytes[i]}, t_e);
                check("fill_full", {31'd0, fifo_full}, 32'd1);
                while (cyc < r_e0 + NB*CPB + 1) @(negedge clk);
                check("fill_full_at_idle", {31'd0, fifo_full}, 32'd1);
                store(1'b1, 32'h100, {24'd0, full_bytes[9]}, t_e);
                check("simul_full_kept", {31'd0, fifo_full}, 32'd1);
                check("simul_no_ovf", {31'd0, overflow}, 32'd0);
            end
            begin
                for (int n = 0; n < 10; n++) begin
                    recv_frame(r_bits, r_s, r_e, r_ok);
                    check("full_frame_ok", {31'd0, r_ok}, 32'd1);
                    check("full_frame_bits", {21'd0, r_bits}, {21'd0, exp_frame(full_bytes[n])});
                end
            end
        join
        check("full_ovf_final", {31'd0, overflow}, 32'd0);
        idle_window("full_drained", 100);

        // Reset mid-frame: during a data bit of 8'hFF, then during START
        reset_mid(50, 1'b1);
        reset_mid(3, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
